// File: rtl/bbox_pkg.sv
// rtl/bbox_pkg.sv - shared types, defaults and field helpers for the bounding-box decoder
package bbox_pkg;

  typedef enum logic [1:0] {
    WAIT_ID,
    WAIT_TL,
    WAIT_BR,
    HOLD
  } state_t;

  localparam logic [31:0] MSG_ID_DEFAULT = 32'h0052_4242;

  // Coordinate words carry {5'b0, x[10:0], 5'b0, y[10:0]}; these bits must be zero.
  localparam logic [31:0] X_PAD_MASK = 32'hF800_0000;
  localparam logic [31:0] Y_PAD_MASK = 32'h0000_F800;
  localparam logic [31:0] PAD_MASK   = X_PAD_MASK | Y_PAD_MASK;

  function automatic logic [10:0] coord_x(input logic [31:0] word);
    return word[26:16];
  endfunction

  function automatic logic [10:0] coord_y(input logic [31:0] word);
    return word[10:0];
  endfunction

endpackage

// File: rtl/bbox_msg_decoder_if.sv
// rtl/bbox_msg_decoder_if.sv - message-in / result-out handshake bundle for the decoder
interface bbox_msg_if;

  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_cx;
  logic [10:0] out_cy;
  logic [10:0] out_w;
  logic [10:0] out_h;
  logic        out_found;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_cx,
    input  out_cy,
    input  out_w,
    input  out_h,
    input  out_found
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_cx,
    output out_cy,
    output out_w,
    output out_h,
    output out_found
  );

endinterface

// File: rtl/bbox_coord_check.sv
// rtl/bbox_coord_check.sv - combinational padding and frame-range check of a coordinate word
module bbox_coord_check
  import bbox_pkg::*;
#(
  parameter int unsigned IMAGE_W = 640,
  parameter int unsigned IMAGE_H = 480
) (
  input  logic [31:0] word_i,
  output logic        legal_o,
  output logic [10:0] x_o,
  output logic [10:0] y_o
);

  logic pad_ok;
  logic x_ok;
  logic y_ok;

  assign x_o    = coord_x(word_i);
  assign y_o    = coord_y(word_i);
  assign pad_ok = ((word_i & PAD_MASK) == 32'd0);
  assign x_ok   = (32'(x_o) < IMAGE_W);
  assign y_ok   = (32'(y_o) < IMAGE_H);

  assign legal_o = pad_ok && x_ok && y_ok;

endmodule

// File: rtl/bbox_msg_decoder.sv
// rtl/bbox_msg_decoder.sv - decodes header/top-left/bottom-right messages into a registered box result
module bbox_msg_decoder
  import bbox_pkg::*;
#(
  parameter logic [31:0] MSG_ID  = MSG_ID_DEFAULT,
  parameter int unsigned IMAGE_W = 640,
  parameter int unsigned IMAGE_H = 480,
  parameter int unsigned MIN_DIM = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  bbox_msg_if.slave   bus,
  output logic [7:0]  err_count,
  output logic [15:0] msg_count
);

  state_t      state_q;
  logic [10:0] x_min_q;
  logic [10:0] y_min_q;
  logic [10:0] cx_q;
  logic [10:0] cy_q;
  logic [10:0] w_q;
  logic [10:0] h_q;
  logic        found_q;
  logic        out_valid_q;
  logic [7:0]  err_q;
  logic [15:0] msg_q;

  logic        word_acc;
  logic        is_hdr;
  logic        coord_legal;
  logic [10:0] word_x;
  logic [10:0] word_y;
  logic [7:0]  err_inc;

  logic [11:0] w_full;
  logic [11:0] h_full;
  logic [11:0] sum_x;
  logic [11:0] sum_y;
  logic        box_found;

  bbox_coord_check #(
    .IMAGE_W (IMAGE_W),
    .IMAGE_H (IMAGE_H)
  ) u_coord_check (
    .word_i  (bus.in_data),
    .legal_o (coord_legal),
    .x_o     (word_x),
    .y_o     (word_y)
  );

  // Gated by reset_n so the port reads 0 during reset and 1 right after release.
  assign bus.in_ready = reset_n && (state_q != HOLD);
  assign word_acc     = bus.in_valid && bus.in_ready;
  assign is_hdr       = (bus.in_data == MSG_ID);
  assign err_inc      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  // Box geometry from the latched top-left and the bottom-right word currently on the bus.
  always_comb begin
    w_full    = {1'b0, word_x} - {1'b0, x_min_q} + 12'd1;
    h_full    = {1'b0, word_y} - {1'b0, y_min_q} + 12'd1;
    sum_x     = {1'b0, x_min_q} + {1'b0, word_x};
    sum_y     = {1'b0, y_min_q} + {1'b0, word_y};
    box_found = (word_x >= x_min_q) && (word_y >= y_min_q) &&
                (32'(w_full) >= MIN_DIM) && (32'(h_full) >= MIN_DIM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= WAIT_ID;
      x_min_q     <= '0;
      y_min_q     <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      found_q     <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
      msg_q       <= '0;
    end else begin
      case (state_q)
        WAIT_ID: begin
          if (word_acc) begin
            if (is_hdr) begin
              state_q <= WAIT_TL;
            end else begin
              err_q <= err_inc;
            end
          end
        end
        WAIT_TL: begin
          if (word_acc) begin
            if (is_hdr) begin
              err_q   <= err_inc;
              state_q <= WAIT_TL;
            end else if (!coord_legal) begin
              err_q   <= err_inc;
              state_q <= WAIT_ID;
            end else begin
              x_min_q <= word_x;
              y_min_q <= word_y;
              state_q <= WAIT_BR;
            end
          end
        end
        WAIT_BR: begin
          if (word_acc) begin
            if (is_hdr) begin
              err_q   <= err_inc;
              state_q <= WAIT_TL;
            end else if (!coord_legal) begin
              err_q   <= err_inc;
              state_q <= WAIT_ID;
            end else begin
              // An inverted or undersized box is still a result, reported as not found.
              found_q     <= box_found;
              cx_q        <= box_found ? 11'(sum_x >> 1) : 11'd0;
              cy_q        <= box_found ? 11'(sum_y >> 1) : 11'd0;
              w_q         <= box_found ? 11'(w_full) : 11'd0;
              h_q         <= box_found ? 11'(h_full) : 11'd0;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            msg_q       <= msg_q + 16'd1;
            state_q     <= WAIT_ID;
          end
        end
        default: begin
          state_q     <= WAIT_ID;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_cx    = cx_q;
  assign bus.out_cy    = cy_q;
  assign bus.out_w     = w_q;
  assign bus.out_h     = h_q;
  assign bus.out_found = found_q;
  assign err_count     = err_q;
  assign msg_count     = msg_q;

endmodule

// File: tb/tb_bbox_msg_decoder.sv
// tb/tb_bbox_msg_decoder.sv - directed and randomized checks of bbox_msg_decoder against a message-level model
module tb_bbox_msg_decoder;

  localparam logic [31:0] HDR = 32'h0052_4242;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  err_count;
  logic [15:0] msg_count;

  bbox_msg_if bus ();

  bbox_msg_decoder #(
    .MSG_ID  (HDR),
    .IMAGE_W (640),
    .IMAGE_H (480),
    .MIN_DIM (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .err_count (err_count),
    .msg_count (msg_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: a message is "open" after a header; coordinates collect until two are held.
  bit m_open;
  int m_xs[$];
  int m_ys[$];
  int m_err;
  int m_msg;
  bit m_hold;
  bit e_found;
  int e_cx, e_cy, e_w, e_h;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void model_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_clear();
    m_open = 0; m_xs.delete(); m_ys.delete();
    m_err = 0; m_msg = 0; m_hold = 0;
  endfunction

  function automatic void model_word(input logic [31:0] w);
    int x, y;
    bit legal;
    x = int'(w[26:16]);
    y = int'(w[10:0]);
    legal = (w[31:27] == 5'd0) && (w[15:11] == 5'd0) && (x < 640) && (y < 480);
    if (w == HDR) begin
      if (m_open) model_err();
      m_open = 1; m_xs.delete(); m_ys.delete();
    end else if (!m_open) begin
      model_err();
    end else if (!legal) begin
      model_err();
      m_open = 0;
    end else begin
      m_xs.push_back(x);
      m_ys.push_back(y);
      if (m_xs.size() == 2) begin
        e_w = m_xs[1] - m_xs[0] + 1;
        e_h = m_ys[1] - m_ys[0] + 1;
        e_found = (m_xs[1] >= m_xs[0]) && (m_ys[1] >= m_ys[0]) && (e_w >= 4) && (e_h >= 4);
        e_cx = e_found ? (m_xs[0] + m_xs[1]) / 2 : 0;
        e_cy = e_found ? (m_ys[0] + m_ys[1]) / 2 : 0;
        if (!e_found) begin e_w = 0; e_h = 0; end
        m_hold = 1;
        m_open = 0;
      end
    end
  endfunction

  task automatic check_result(input string tag);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, ".found"}, 32'(bus.out_found), 32'(e_found));
    check({tag, ".cx"}, 32'(bus.out_cx), 32'(e_cx));
    check({tag, ".cy"}, 32'(bus.out_cy), 32'(e_cy));
    check({tag, ".w"}, 32'(bus.out_w), 32'(e_w));
    check({tag, ".h"}, 32'(bus.out_h), 32'(e_h));
  endtask

  task automatic collect(input int hold_cycles);
    check_result("result");
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      check_result("hold");
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    m_hold = 0;
    m_msg = (m_msg + 1) % 65536;
    check("consume.valid", 32'(bus.out_valid), 32'd0);
    check("consume.ready", 32'(bus.in_ready), 32'd1);
    check("msg_count", 32'(msg_count), 32'(m_msg));
  endtask

  task automatic send_word(input logic [31:0] w, input int hold_cycles);
    @(negedge clk);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_word(w);
    check("err_count", 32'(err_count), 32'(m_err));
    if (m_hold) collect(hold_cycles);
    else check("no_result", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.found", 32'(bus.out_found), 32'd0);
    check("rst.cxcy", {5'd0, bus.out_cx, 5'd0, bus.out_cy}, 32'd0);
    check("rst.wh", {5'd0, bus.out_w, 5'd0, bus.out_h}, 32'd0);
    check("rst.err", 32'(err_count), 32'd0);
    check("rst.msg", 32'(msg_count), 32'd0);
    @(negedge clk); reset_n = 1'b1; #1;
    check("rst.release_ready", 32'(bus.in_ready), 32'd1);
    model_clear();
  endtask

  initial begin
    logic [31:0] w;
    int k, x, y, lx, ly;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    model_clear();
    lx = 0; ly = 0;

    do_reset();

    // Basic box: centre (20,35), size 21x31.
    send_word(HDR, 0);
    send_word(32'h000A_0014, 0);
    send_word(32'h001E_0032, 0);
    check("basic.msg", 32'(msg_count), 32'd1);

    // "Nothing detected" inverted box is a result, not an error.
    send_word(HDR, 1);
    send_word(32'h027F_01DF, 1);
    send_word(32'h0000_0000, 1);
    check("inverted.err", 32'(err_count), 32'd0);

    // Garbage then a good message.
    send_word(32'h1234_5678, 0);
    check("garbage.err", 32'(err_count), 32'd1);
    send_word(HDR, 0);
    send_word(32'h0064_0064, 0);
    send_word(32'h0070_0080, 0);

    // Padding bit set, then x at the frame width; a following coordinate has no header.
    send_word(HDR, 0);
    send_word(32'h0800_0005, 0);
    send_word(32'h000A_0014, 0);
    send_word(HDR, 0);
    send_word(32'h0280_0000, 0);
    send_word(HDR, 0);
    send_word(32'h0000_01E0, 0);

    // Header mid-message restarts; box at the far frame corner, 4x4 exactly.
    send_word(HDR, 0);
    send_word(32'h0005_0005, 0);
    send_word(HDR, 0);
    send_word(32'h027C_01DC, 0);
    send_word(32'h027F_01DF, 0);
    // 3 pixels wide: not found.
    send_word(HDR, 0);
    send_word(32'h0010_0010, 0);
    send_word(32'h0012_0020, 0);

    // Back-pressure for 10 cycles.
    send_word(HDR, 10);
    send_word(32'h0001_0002, 10);
    send_word(32'h0100_0150, 10);

    for (int i = 0; i < 250; i++) begin
      k = int'($urandom_range(0, 9));
      x = int'($urandom_range(0, 639));
      y = int'($urandom_range(0, 479));
      if (k >= 7) begin
        x = lx + int'($urandom_range(0, 40)) - 5;
        y = ly + int'($urandom_range(0, 40)) - 5;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        if (x > 639) x = 639;
        if (y > 479) y = 479;
      end
      case (k)
        0, 1: w = HDR;
        2: w = $urandom;
        3: w = {5'd0, 11'($urandom_range(640, 2047)), 5'd0, 11'($urandom_range(0, 479))};
        default: w = {5'd0, 11'(x), 5'd0, 11'(y)};
      endcase
      if (k >= 4) begin lx = x; ly = y; end
      send_word(w, int'($urandom_range(0, 3)));
    end

    // Reset mid-message discards it silently.
    send_word(HDR, 0);
    send_word(32'h0002_0003, 0);
    do_reset();
    send_word(32'h0040_0040, 0);
    check("post_reset.err", 32'(err_count), 32'd1);

    do_reset();
    for (int i = 0; i < 300; i++) send_word(32'hDEAD_0000 + 32'(i), 0);
    check("saturate.err", 32'(err_count), 32'd255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bbox_msg_decoder.md
BBOX_MSG_DECODER -- requirements
Module: bbox_msg_decoder

Interface
REQ-001 SHALL have parameter MSG_ID, default 32'h00524242 ("RBB"), the message header word.
REQ-002 SHALL have parameter IMAGE_W, default 640, the frame width in pixels; x coordinates are valid in 0..IMAGE_W-1.
REQ-003 SHALL have parameter IMAGE_H, default 480, the frame height in pixels; y coordinates are valid in 0..IMAGE_H-1.
REQ-004 SHALL have parameter MIN_DIM, default 4, the minimum box width/height in pixels for a detection.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port in_data, input, 32, message word: header, then {5'b0,x[10:0],5'b0,y[10:0]} top-left, then bottom-right.
REQ-008 SHALL have port in_valid, input, 1, in_data valid.
REQ-009 SHALL have port in_ready, output, 1, decoder accepts in_data.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have ports out_cx and out_cy, output, 11 each, box centre.
REQ-013 SHALL have ports out_w and out_h, output, 11 each, box width and height.
REQ-014 SHALL have port out_found, output, 1, the box is a valid detection.
REQ-015 SHALL have port err_count, output, 8, saturating count of protocol errors.
REQ-016 SHALL have port msg_count, output, 16, wrapping count of results delivered.

Function
REQ-017 SHALL transfer an input word only on a cycle with in_valid=1 and in_ready=1, and a result only on a cycle with out_valid=1 and out_ready=1.
REQ-018 SHALL implement FSM states WAIT_ID, WAIT_TL, WAIT_BR, HOLD.
- in_ready=1 in every state except HOLD.
- out_valid=1 only in HOLD.
REQ-019 In WAIT_ID, an accepted word equal to MSG_ID SHALL move to WAIT_TL; any other accepted word SHALL be discarded and increment err_count.
REQ-020 In WAIT_TL or WAIT_BR, an accepted word SHALL be rejected when any padding bit ([31:27] or [15:11]) is nonzero, or x>=IMAGE_W, or y>=IMAGE_H: err_count increments and the FSM returns to WAIT_ID.
REQ-021 In WAIT_TL or WAIT_BR, an accepted word equal to MSG_ID SHALL increment err_count and move to WAIT_TL, restarting the message.
REQ-022 A legal word SHALL be latched as (x_min,y_min) in WAIT_TL, moving to WAIT_BR, and as (x_max,y_max) in WAIT_BR, moving to HOLD.
REQ-023 out_valid SHALL rise on the cycle after the bottom-right word is accepted (latency 1 cycle), with all outputs registered and stable while out_valid=1.
REQ-024 out_found SHALL be 1 iff x_max>=x_min, y_max>=y_min, w>=MIN_DIM and h>=MIN_DIM.
REQ-025 When out_found=1:
- out_w = x_max-x_min+1 and out_h = y_max-y_min+1;
- out_cx = (x_min+x_max)>>1 and out_cy = (y_min+y_max)>>1;
- sums SHALL be computed 12 bits wide, with no overflow.
REQ-026 When out_found=0, out_cx, out_cy, out_w and out_h SHALL all be 0; an inverted box (the "nothing detected" case, e.g. min=639, max=0) SHALL be delivered as a result, not counted as an error.
REQ-027 On a HOLD handshake, msg_count SHALL increment (wrapping 16'hFFFF->0) and the FSM SHALL return to WAIT_ID; HOLD SHALL persist indefinitely while out_ready=0.
REQ-028 err_count SHALL saturate at 8'hFF.
REQ-029 At most one error SHALL be counted per accepted word.

Reset
REQ-030 While reset_n=0 at a clk edge:
- state=WAIT_ID, out_valid=0, in_ready=0 during reset;
- out_cx, out_cy, out_w, out_h and out_found = 0;
- err_count=0 and msg_count=0.
REQ-031 Reset asserted mid-message or in HOLD SHALL discard the partial or pending result without counting an error.
REQ-032 in_ready SHALL be 1 on the first cycle after reset_n rises.

Structure
REQ-033 SHALL place the FSM state enumeration, the default MSG_ID, and the padding-field masks in shared package bbox_pkg.
REQ-034 SHALL place the coordinate field check (padding-zero and range check) in one sub-module, bbox_coord_check, which is purely combinational and instanced once.

Verification
REQ-035 Send 0x00524242, 0x000A0014, 0x001E0032 with out_ready=1 -> next cycle out_valid=1, found=1, cx=20, cy=35, w=21, h=31; msg_count=1.
REQ-036 Send header, 0x027F01DF, 0x00000000 -> found=0, cx=cy=w=h=0; err_count unchanged.
REQ-037 Send 0x12345678 then a valid 3-word message -> err_count=1, then a correct result delivered.
REQ-038 Send header, 0x08000005 (padding bit set) -> err_count+1, state WAIT_ID; also send header, 0x02800000 (x=640) -> err_count+1.
REQ-039 Hold out_ready=0 for 10 cycles after a result -> in_ready=0, outputs stable; release -> a single msg_count increment.
REQ-040 Send header, TL, then pulse reset -> no output, err_count=0; also drive 300 bad words -> err_count=255.
